// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: two-requester round-robin packet arbiter that frames
// PID / payload / optional CRC16 onto one valid-ready transmit channel.
// Ports: clk, reset (async, active low); req/pid/data/last per requester;
//   pop (one-hot byte consumed), gnt (one-hot owner), tx_data/tx_valid/
//   tx_ready (transmit channel), busy (not IDLE), pkt_cnt (done packets).
// Option: define USB_TX_CRC16_EN to append the USB CRC16 (lo, hi) bytes.
module usb_tx_arbiter #(
  parameter int IDLE_GAP = 2,
  parameter int MAX_LEN  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  pid0,
  input  logic [3:0]  pid1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  input  logic        last0,
  input  logic        last1,
  output logic [1:0]  pop,
  output logic [1:0]  gnt,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam int LW = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CRC1,
    S_CRC2,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [1:0]    gnt_q;
  logic          rr_q;
  logic [LW-1:0] len_q;
  logic [GW-1:0] gap_q;
  logic [15:0]   pkt_cnt_q;

  logic          pick1_d;
  logic [3:0]    sel_pid;
  logic [7:0]    sel_data;
  logic          sel_last;
  logic          xfer;
  logic          data_end;
  logic          pkt_done;

`ifdef USB_TX_CRC16_EN
  logic [15:0]   crc_q;
  logic [15:0]   crc_out;

  // Reflected form of poly 0x8005: shift right, xor 0xA001.
  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_out = ~crc_q;
`endif

  // Both requesting: grant the one not served last.
  assign pick1_d  = (req0 && req1) ? ~rr_q : req1;

  assign sel_pid  = gnt_q[1] ? pid1  : pid0;
  assign sel_data = gnt_q[1] ? data1 : data0;
  assign sel_last = gnt_q[1] ? last1 : last0;

  assign tx_valid = (state_q == S_PID)  ||
                    (state_q == S_DATA) ||
                    (state_q == S_CRC1) ||
                    (state_q == S_CRC2);

  assign xfer     = tx_valid && tx_ready;
  assign data_end = sel_last || (len_q == LW'(MAX_LEN - 1));

`ifdef USB_TX_CRC16_EN
  assign pkt_done = (state_q == S_CRC2) && xfer;
`else
  assign pkt_done = (state_q == S_DATA) && xfer && data_end;
`endif

  assign pop     = ((state_q == S_DATA) && tx_ready) ? gnt_q : 2'b00;
  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign pkt_cnt = pkt_cnt_q;

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      S_PID:  tx_data = {~sel_pid, sel_pid};
      S_DATA: tx_data = sel_data;
`ifdef USB_TX_CRC16_EN
      S_CRC1: tx_data = crc_out[7:0];
      S_CRC2: tx_data = crc_out[15:8];
`endif
      default: tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      rr_q      <= 1'b1;
      len_q     <= '0;
      gap_q     <= '0;
      pkt_cnt_q <= 16'h0000;
`ifdef USB_TX_CRC16_EN
      crc_q     <= 16'hFFFF;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          len_q <= '0;
`ifdef USB_TX_CRC16_EN
          crc_q <= 16'hFFFF;
`endif
          if (req0 || req1) begin
            state_q <= S_PID;
            gnt_q   <= pick1_d ? 2'b10 : 2'b01;
            rr_q    <= pick1_d;
          end
        end
        S_PID: begin
          if (xfer) state_q <= S_DATA;
        end
        S_DATA: begin
          if (xfer) begin
            len_q <= len_q + LW'(1);
`ifdef USB_TX_CRC16_EN
            crc_q <= crc_upd(crc_q, sel_data);
            if (data_end) state_q <= S_CRC1;
`endif
          end
        end
`ifdef USB_TX_CRC16_EN
        S_CRC1: begin
          if (xfer) state_q <= S_CRC2;
        end
`endif
        S_GAP: begin
          if (gap_q == GW'(IDLE_GAP - 1)) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: ;
      endcase
      if (pkt_done) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
        gnt_q     <= 2'b00;
        gap_q     <= '0;
        state_q   <= (IDLE_GAP == 0) ? S_IDLE : S_GAP;
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: directed vector table plus hand-written sequences
// for usb_tx_arbiter (MAX_LEN=4, IDLE_GAP=2).
module tb_usb_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [3:0]  pid0, pid1;
  logic [7:0]  data0, data1;
  logic        last0, last1;
  logic [1:0]  pop, gnt;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        busy;
  logic [15:0] pkt_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usb_tx_arbiter #(.IDLE_GAP(2), .MAX_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .pid0(pid0), .pid1(pid1),
    .data0(data0), .data1(data1),
    .last0(last0), .last1(last1),
    .pop(pop), .gnt(gnt),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  typedef struct {
    logic [1:0] req;
    logic [3:0] p0, p1;
    logic [7:0] d0, d1;
    logic [1:0] lst;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ep, eg;
    logic       eb;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic [1:0] req, input logic [3:0] p0, input logic [3:0] p1,
    input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] lst,
    input logic rdy, input logic ev, input logic [7:0] ed,
    input logic [1:0] ep, input logic [1:0] eg, input logic eb
  );
    vec_t v;
    v.req = req; v.p0 = p0; v.p1 = p1; v.d0 = d0; v.d1 = d1;
    v.lst = lst; v.rdy = rdy; v.ev = ev; v.ed = ed;
    v.ep = ep; v.eg = eg; v.eb = eb;
    vq.push_back(v);
  endfunction

  // Bit-serial LSB-first CRC16/USB register step.
  function automatic logic [15:0] crc_step(
    input logic [15:0] c, input logic [7:0] d
  );
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int t = 0; t < 30 && g == 2'b00; t++) begin
      @(negedge clk);
      #1;
      g = gnt;
    end
  endtask

  task automatic wait_idle(input logic [1:0] g, output logic bad);
    bad = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      #1;
      if (gnt != 2'b00 && gnt != g) bad = 1'b1;
      if (!busy) break;
    end
  endtask

  initial begin
    logic [15:0] c1, c2;
    logic [1:0]  g;
    logic        bad;
    int          npop, npop1, nval;
    logic        started;
    logic [1:0]  exp_g [3];

    c1 = 16'hFFFF;
    for (int i = 0; i < 4; i++) c1 = crc_step(c1, 8'(i));
    c1 = ~c1;
    c2 = crc_step(crc_step(16'hFFFF, 8'hAA), 8'h55);
    c2 = ~c2;

    // Packet A: requester 0, PID 3, bytes 00..03, always ready.
    add(2'b01, 4'h3, 4'h0, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 2'b00, 2'b00, 0);
    add(2'b10, 4'h3, 4'h0, 8'h00, 8'h00, 2'b00, 1, 1, 8'hC3, 2'b00, 2'b01, 1);
    add(2'b10, 4'h3, 4'h0, 8'h00, 8'h00, 2'b00, 1, 1, 8'h00, 2'b01, 2'b01, 1);
    add(2'b10, 4'h3, 4'h0, 8'h01, 8'h00, 2'b00, 1, 1, 8'h01, 2'b01, 2'b01, 1);
    add(2'b10, 4'h3, 4'h0, 8'h02, 8'h00, 2'b00, 1, 1, 8'h02, 2'b01, 2'b01, 1);
    add(2'b10, 4'h3, 4'h0, 8'h03, 8'h00, 2'b01, 1, 1, 8'h03, 2'b01, 2'b01, 1);
`ifdef USB_TX_CRC16_EN
    add(2'b00, 4'h3, 4'h0, 8'h00, 8'h00, 2'b00, 1, 1, c1[7:0],  2'b00, 2'b01, 1);
    add(2'b00, 4'h3, 4'h0, 8'h00, 8'h00, 2'b00, 1, 1, c1[15:8], 2'b00, 2'b01, 1);
`endif
    add(2'b11, 4'h3, 4'h0, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 2'b00, 2'b00, 1);
    add(2'b11, 4'h3, 4'h0, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 2'b00, 2'b00, 1);
    // Packet B: requester 1, PID 9, bytes AA 55, ready toggling.
    add(2'b10, 4'h0, 4'h9, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 2'b00, 2'b00, 0);
    add(2'b10, 4'h0, 4'h9, 8'h00, 8'hAA, 2'b00, 0, 1, 8'h69, 2'b00, 2'b10, 1);
    add(2'b10, 4'h0, 4'h9, 8'h00, 8'hAA, 2'b00, 1, 1, 8'h69, 2'b00, 2'b10, 1);
    add(2'b10, 4'h0, 4'h9, 8'h00, 8'hAA, 2'b00, 0, 1, 8'hAA, 2'b00, 2'b10, 1);
    add(2'b10, 4'h0, 4'h9, 8'h00, 8'hAA, 2'b00, 1, 1, 8'hAA, 2'b10, 2'b10, 1);
    add(2'b00, 4'h0, 4'h9, 8'h00, 8'h55, 2'b10, 0, 1, 8'h55, 2'b00, 2'b10, 1);
    add(2'b00, 4'h0, 4'h9, 8'h00, 8'h55, 2'b10, 1, 1, 8'h55, 2'b10, 2'b10, 1);
`ifdef USB_TX_CRC16_EN
    add(2'b00, 4'h0, 4'h9, 8'h00, 8'h00, 2'b00, 0, 1, c2[7:0],  2'b00, 2'b10, 1);
    add(2'b00, 4'h0, 4'h9, 8'h00, 8'h00, 2'b00, 1, 1, c2[7:0],  2'b00, 2'b10, 1);
    add(2'b00, 4'h0, 4'h9, 8'h00, 8'h00, 2'b00, 1, 1, c2[15:8], 2'b00, 2'b10, 1);
`endif
    add(2'b00, 4'h0, 4'h9, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 2'b00, 2'b00, 1);
    add(2'b00, 4'h0, 4'h9, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 2'b00, 2'b00, 1);
    add(2'b00, 4'h0, 4'h9, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 2'b00, 2'b00, 0);

    reset = 1'b0;
    {req0, req1, last0, last1, tx_ready} = '0;
    {pid0, pid1, data0, data1} = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst valid", 32'(tx_valid), 0);
    chk("rst data",  32'(tx_data), 0);
    chk("rst gnt",   32'(gnt), 0);
    chk("rst pop",   32'(pop), 0);
    chk("rst busy",  32'(busy), 0);
    chk("rst cnt",   32'(pkt_cnt), 0);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      {req1, req0}   = vq[i].req;
      pid0 = vq[i].p0; pid1 = vq[i].p1;
      data0 = vq[i].d0; data1 = vq[i].d1;
      {last1, last0} = vq[i].lst;
      tx_ready = vq[i].rdy;
      #1;
      chk($sformatf("v%0d valid", i), 32'(tx_valid), 32'(vq[i].ev));
      chk($sformatf("v%0d data", i),  32'(tx_data),  32'(vq[i].ed));
      chk($sformatf("v%0d pop", i),   32'(pop),      32'(vq[i].ep));
      chk($sformatf("v%0d gnt", i),   32'(gnt),      32'(vq[i].eg));
      chk($sformatf("v%0d busy", i),  32'(busy),     32'(vq[i].eb));
    end
    chk("cnt after table", 32'(pkt_cnt), 2);

    // Round robin with both requesters held: order 0,1,0.
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    {last0, last1, tx_ready} = 3'b111;
    {req0, req1} = 2'b11;
    for (int p = 0; p < 3; p++) begin
      wait_gnt(g);
      if (p == 2) {req0, req1} = 2'b00;
      chk($sformatf("rr gnt %0d", p), 32'(g), 32'(exp_g[p]));
      wait_idle(g, bad);
      chk($sformatf("rr hold %0d", p), 32'(bad), 0);
      chk($sformatf("rr done %0d", p), 32'(busy), 0);
    end
    chk("cnt after rr", 32'(pkt_cnt), 5);

    // MAX_LEN truncation: last never asserted.
    {last0, last1} = 2'b00;
    pid0 = 4'h5;
    req0 = 1'b1;
    npop = 0; npop1 = 0; nval = 0; started = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      data0 = 8'(t);
      if (gnt != 2'b00) req0 = 1'b0;
      #1;
      if (pop[0]) npop++;
      if (pop[1]) npop1++;
      if (tx_valid) nval++;
      if (started && !busy) break;
      if (busy) started = 1'b1;
    end
    chk("trunc pops", 32'(npop), 4);
    chk("trunc pops1", 32'(npop1), 0);
`ifdef USB_TX_CRC16_EN
    chk("trunc beats", 32'(nval), 7);
`else
    chk("trunc beats", 32'(nval), 5);
`endif
    chk("trunc cnt", 32'(pkt_cnt), 6);

    // Reset in the middle of DATA.
    req0 = 1'b1;
    wait_gnt(g);
    req0 = 1'b0;
    chk("mid gnt", 32'(g), 1);
    @(negedge clk);
    #1;
    chk("mid pop before rst", 32'(pop), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid rst valid", 32'(tx_valid), 0);
    chk("mid rst data",  32'(tx_data), 0);
    chk("mid rst pop",   32'(pop), 0);
    chk("mid rst gnt",   32'(gnt), 0);
    chk("mid rst busy",  32'(busy), 0);
    chk("mid rst cnt",   32'(pkt_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    {req0, req1} = 2'b11;
    {last0, last1} = 2'b11;
    wait_gnt(g);
    {req0, req1} = 2'b00;
    chk("post rst gnt", 32'(g), 1);
    wait_idle(g, bad);
    chk("post rst cnt", 32'(pkt_cnt), 1);

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.pkt_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_cnt_q;
    #1;
    chk("wrap preset", 32'(pkt_cnt), 32'hFFFF);
    req0 = 1'b1;
    wait_gnt(g);
    req0 = 1'b0;
    wait_idle(g, bad);
    chk("wrap cnt", 32'(pkt_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
